// File: rtl/reg_apb_pkg.sv
// Shared types and constants for the REG_BUS to APB4 bridge.
package reg_apb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_e;

  localparam int unsigned APB_AW = 32;
  localparam int unsigned APB_DW = 32;
  localparam int unsigned APB_SW = APB_DW / 8;

  localparam logic [2:0] PPROT_DEFAULT = 3'b000;

  // Stall counter width: enough to hold the timeout value, never below one bit.
  function automatic int unsigned cnt_width(input int unsigned timeout);
    int unsigned w;
    w = $clog2(timeout + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/reg_to_apb.sv
// REG_BUS slave to APB4 master bridge. Each request is captured in IDLE,
// sequenced through SETUP and ACCESS, and answered with a one-cycle ready in
// RESP. An optional stall counter turns a hung APB slave into an error.
//
// state  | meaning
// IDLE   | waiting for valid; captures the request fields
// SETUP  | APB setup phase, psel high, penable low
// ACCESS | APB access phase, waiting for pready (or stall timeout)
// RESP   | registered ready pulse back to the REG_BUS master
module reg_to_apb
  import reg_apb_pkg::*;
#(
  parameter int unsigned TimeoutCycles = 1024,
  parameter logic [2:0]  PprotValue    = PPROT_DEFAULT
) (
  input  logic              clk_i,
  input  logic              rst_i,
  // REG_BUS slave side
  input  logic [APB_AW-1:0] reg_addr_i,
  input  logic              reg_write_i,
  input  logic [APB_DW-1:0] reg_wdata_i,
  input  logic [APB_SW-1:0] reg_wstrb_i,
  input  logic              reg_valid_i,
  output logic [APB_DW-1:0] reg_rdata_o,
  output logic              reg_ready_o,
  output logic              reg_error_o,
  // APB4 master side
  output logic [APB_AW-1:0] paddr_o,
  output logic              psel_o,
  output logic              penable_o,
  output logic              pwrite_o,
  output logic [APB_DW-1:0] pwdata_o,
  output logic [APB_SW-1:0] pstrb_o,
  output logic [2:0]        pprot_o,
  input  logic [APB_DW-1:0] prdata_i,
  input  logic              pready_i,
  input  logic              pslverr_i
);

  localparam int unsigned CntW = cnt_width(TimeoutCycles);

  state_e            state_q, state_d;
  logic [APB_AW-1:0] addr_q, addr_d;
  logic              write_q, write_d;
  logic [APB_DW-1:0] wdata_q, wdata_d;
  logic [APB_SW-1:0] strb_q, strb_d;
  logic [APB_DW-1:0] rdata_q, rdata_d;
  logic              error_q, error_d;
  logic [CntW-1:0]   cnt_q, cnt_d;

  // State and capture registers; reset clears everything so the APB and
  // REG_BUS outputs fall to zero immediately, even mid-transfer.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      addr_q  <= '0;
      write_q <= 1'b0;
      wdata_q <= '0;
      strb_q  <= '0;
      rdata_q <= '0;
      error_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      write_q <= write_d;
      wdata_q <= wdata_d;
      strb_q  <= strb_d;
      rdata_q <= rdata_d;
      error_q <= error_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state, request capture, response capture and stall counting.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    write_d = write_q;
    wdata_d = wdata_q;
    strb_d  = strb_q;
    rdata_d = rdata_q;
    error_d = error_q;
    cnt_d   = cnt_q;

    case (state_q)
      IDLE: begin
        if (reg_valid_i) begin
          addr_d  = reg_addr_i;
          write_d = reg_write_i;
          wdata_d = reg_wdata_i;
          // Reads never carry strobes on APB4.
          strb_d  = reg_write_i ? reg_wstrb_i : '0;
          cnt_d   = '0;
          state_d = SETUP;
        end
      end

      SETUP: begin
        state_d = ACCESS;
      end

      ACCESS: begin
        if (pready_i) begin
          rdata_d = write_q ? '0 : prdata_i;
          error_d = pslverr_i;
          state_d = RESP;
        end else begin
          if (cnt_q != '1) begin
            cnt_d = cnt_q + 1'b1;
          end
          if ((TimeoutCycles != 0) && (cnt_d == CntW'(TimeoutCycles))) begin
            rdata_d = '0;
            error_d = 1'b1;
            state_d = RESP;
          end
        end
      end

      RESP: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign psel_o      = (state_q == SETUP) || (state_q == ACCESS);
  assign penable_o   = (state_q == ACCESS);
  assign reg_ready_o = (state_q == RESP);

  assign paddr_o     = addr_q;
  assign pwrite_o    = write_q;
  assign pwdata_o    = wdata_q;
  assign pstrb_o     = strb_q;
  assign pprot_o     = PprotValue;

  assign reg_rdata_o = rdata_q;
  assign reg_error_o = error_q;

endmodule

// File: tb/tb_reg_to_apb.sv
// Self-checking bench for reg_to_apb: directed scenarios plus randomized
// transfers, each compared against a transaction-level expectation.
module tb_reg_to_apb;

  localparam int unsigned TO   = 8;
  localparam logic [2:0]  PROT = 3'b101;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] reg_addr = '0;
  logic        reg_write = 1'b0;
  logic [31:0] reg_wdata = '0;
  logic [3:0]  reg_wstrb = '0;
  logic        reg_valid = 1'b0;
  logic [31:0] reg_rdata;
  logic        reg_ready;
  logic        reg_error;
  logic [31:0] paddr;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [31:0] pwdata;
  logic [3:0]  pstrb;
  logic [2:0]  pprot;
  logic [31:0] prdata = '0;
  logic        pready = 1'b0;
  logic        pslverr = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [31:0] addr;
    logic        wr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    int          waits;
    logic [31:0] prdata;
    logic        slverr;
  } txn_t;

  reg_to_apb #(.TimeoutCycles(TO), .PprotValue(PROT)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .reg_addr_i  (reg_addr),
    .reg_write_i (reg_write),
    .reg_wdata_i (reg_wdata),
    .reg_wstrb_i (reg_wstrb),
    .reg_valid_i (reg_valid),
    .reg_rdata_o (reg_rdata),
    .reg_ready_o (reg_ready),
    .reg_error_o (reg_error),
    .paddr_o     (paddr),
    .psel_o      (psel),
    .penable_o   (penable),
    .pwrite_o    (pwrite),
    .pwdata_o    (pwdata),
    .pstrb_o     (pstrb),
    .pprot_o     (pprot),
    .prdata_i    (prdata),
    .pready_i    (pready),
    .pslverr_i   (pslverr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic check_fields(input txn_t t);
    check("paddr", paddr, t.addr);
    check("pwrite", 32'(pwrite), 32'(t.wr));
    check("pwdata", pwdata, t.wdata);
    check("pstrb", 32'(pstrb), t.wr ? 32'(t.wstrb) : 32'h0);
    check("pprot", 32'(pprot), 32'(PROT));
  endtask

  // Called at a negedge; drives the request, acts as APB slave, and returns
  // at the negedge of the IDLE cycle that follows RESP.
  task automatic run_txn(input txn_t t, input bit keep_valid);
    bit          to;
    int          acc;
    logic [31:0] exp_rdata;
    logic        exp_err;

    to        = (TO != 0) && (t.waits >= int'(TO));
    acc       = to ? int'(TO) : t.waits + 1;
    exp_err   = to ? 1'b1 : t.slverr;
    exp_rdata = (to || t.wr) ? 32'h0 : t.prdata;

    reg_valid = 1'b1;
    reg_addr  = t.addr;
    reg_write = t.wr;
    reg_wdata = t.wdata;
    reg_wstrb = t.wstrb;

    @(posedge clk); @(negedge clk);
    check("setup_psel", 32'(psel), 32'h1);
    check("setup_penable", 32'(penable), 32'h0);
    check("setup_ready", 32'(reg_ready), 32'h0);
    check_fields(t);

    for (int k = 1; k <= acc; k++) begin
      @(posedge clk); @(negedge clk);
      check("access_psel", 32'(psel), 32'h1);
      check("access_penable", 32'(penable), 32'h1);
      check("access_ready", 32'(reg_ready), 32'h0);
      check_fields(t);
      if (!to && k == t.waits + 1) begin
        pready  = 1'b1;
        prdata  = t.prdata;
        pslverr = t.slverr;
      end else begin
        pready  = 1'b0;
        prdata  = $urandom;
        pslverr = 1'($urandom_range(0, 1));
      end
    end

    @(posedge clk); @(negedge clk);
    pready  = 1'b0;
    pslverr = 1'b0;
    check("resp_ready", 32'(reg_ready), 32'h1);
    check("resp_error", 32'(reg_error), 32'(exp_err));
    check("resp_rdata", reg_rdata, exp_rdata);
    check("resp_psel", 32'(psel), 32'h0);
    check("resp_penable", 32'(penable), 32'h0);
    if (!keep_valid) reg_valid = 1'b0;

    @(posedge clk); @(negedge clk);
    check("idle_ready", 32'(reg_ready), 32'h0);
    check("idle_psel", 32'(psel), 32'h0);
    check("idle_penable", 32'(penable), 32'h0);
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); @(negedge clk);
      check("gap_psel", 32'(psel), 32'h0);
      check("gap_ready", 32'(reg_ready), 32'h0);
    end
  endtask

  function automatic txn_t rand_txn();
    txn_t t;
    t.addr   = $urandom;
    t.wr     = 1'($urandom_range(0, 1));
    t.wdata  = $urandom;
    t.wstrb  = 4'($urandom_range(0, 15));
    t.waits  = int'($urandom_range(0, 10));
    t.prdata = $urandom;
    t.slverr = 1'($urandom_range(0, 3) == 0);
    return t;
  endfunction

  task automatic reset_mid_access();
    txn_t t;
    t = rand_txn();
    t.wr = 1'b1;
    reg_valid = 1'b1;
    reg_addr  = t.addr;
    reg_write = t.wr;
    reg_wdata = t.wdata;
    reg_wstrb = t.wstrb;
    @(posedge clk); @(negedge clk);
    @(posedge clk); @(negedge clk);
    pready = 1'b0;
    check("pre_rst_penable", 32'(penable), 32'h1);
    #2 rst = 1'b1;
    #1;
    check("rst_psel", 32'(psel), 32'h0);
    check("rst_penable", 32'(penable), 32'h0);
    check("rst_ready", 32'(reg_ready), 32'h0);
    check("rst_paddr", paddr, 32'h0);
    check("rst_pwdata", pwdata, 32'h0);
    check("rst_pstrb", 32'(pstrb), 32'h0);
    check("rst_pwrite", 32'(pwrite), 32'h0);
    reg_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_hold_ready", 32'(reg_ready), 32'h0);
    end
    rst = 1'b0;
    idle_cycles(3);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    txn_t t, t2;
    bit   keep;

    #2 rst = 1'b1;
    #3;
    check("reset_psel", 32'(psel), 32'h0);
    check("reset_penable", 32'(penable), 32'h0);
    check("reset_pwrite", 32'(pwrite), 32'h0);
    check("reset_paddr", paddr, 32'h0);
    check("reset_pwdata", pwdata, 32'h0);
    check("reset_pstrb", 32'(pstrb), 32'h0);
    check("reset_ready", 32'(reg_ready), 32'h0);
    check("reset_error", 32'(reg_error), 32'h0);
    check("reset_rdata", reg_rdata, 32'h0);
    check("reset_pprot", 32'(pprot), 32'(PROT));
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    idle_cycles(2);

    // Zero-wait read
    t = '{addr: 32'h0000_1004, wr: 1'b0, wdata: 32'h0, wstrb: 4'hF,
          waits: 0, prdata: 32'hDEAD_BEEF, slverr: 1'b0};
    run_txn(t, 1'b0);
    idle_cycles(1);

    // Write with three wait states
    t = '{addr: 32'h0000_2008, wr: 1'b1, wdata: 32'h1234_5678, wstrb: 4'b0101,
          waits: 3, prdata: 32'h0, slverr: 1'b0};
    run_txn(t, 1'b0);

    // Read with slave error
    t = '{addr: 32'h0000_300C, wr: 1'b0, wdata: 32'h0, wstrb: 4'h0,
          waits: 1, prdata: 32'hA5A5_A5A5, slverr: 1'b1};
    run_txn(t, 1'b0);

    // Write with no strobes still goes out
    t = '{addr: 32'h0000_4000, wr: 1'b1, wdata: 32'hCAFE_F00D, wstrb: 4'b0000,
          waits: 0, prdata: 32'h0, slverr: 1'b0};
    run_txn(t, 1'b0);

    // Stall timeout, then a normal transfer
    t = '{addr: 32'h0000_5000, wr: 1'b0, wdata: 32'h0, wstrb: 4'h0,
          waits: 50, prdata: 32'h1111_2222, slverr: 1'b0};
    run_txn(t, 1'b0);
    t = '{addr: 32'h0000_5004, wr: 1'b0, wdata: 32'h0, wstrb: 4'h0,
          waits: int'(TO) - 1, prdata: 32'h3333_4444, slverr: 1'b0};
    run_txn(t, 1'b0);

    // Back-to-back with valid held across ready
    t  = rand_txn();
    t2 = rand_txn();
    t.waits  = 1;
    t2.waits = 0;
    run_txn(t, 1'b1);
    run_txn(t2, 1'b0);
    idle_cycles(2);

    // Reset during ACCESS, then recovery
    reset_mid_access();
    t = '{addr: 32'h0000_6000, wr: 1'b0, wdata: 32'h0, wstrb: 4'h0,
          waits: 2, prdata: 32'h7777_8888, slverr: 1'b0};
    run_txn(t, 1'b0);

    // Randomized traffic
    for (int i = 0; i < 40; i++) begin
      t = rand_txn();
      keep = (i != 39) && ($urandom_range(0, 2) == 0);
      run_txn(t, keep);
      if (!keep) idle_cycles(int'($urandom_range(0, 2)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
